attention_av_loader: RTL and testbench



---
 rtl/av_pkg.sv | 16 +
 rtl/av_prec_classify.sv | 41 ++++
 rtl/attention_av_loader.sv | 178 +++++++++++++++++
 tb/tb_attention_av_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/av_pkg.sv
// Shared types for the A*V attention loader and multiplier.
// Holds the loader FSM encoding and the per-column precision codes.
package av_pkg;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_V,
        FIRE,
        WAIT
    } av_state_e;

    localparam logic [1:0] PREC_INT4 = 2'b00;
    localparam logic [1:0] PREC_INT8 = 2'b01;
    localparam logic [1:0] PREC_FP16 = 2'b10;

endpackage

// File: rtl/av_prec_classify.sv
// Saturating |word|, running max against colmax, and threshold
// compare to a 2-bit precision code. Purely combinational.
module av_prec_classify
    import av_pkg::*;
#(
    parameter int                  WIDTH       = 16,
    parameter logic [WIDTH-1:0]    THRESH_INT4 = 16'h0800,
    parameter logic [WIDTH-1:0]    THRESH_INT8 = 16'h2000
) (
    input  logic [WIDTH-1:0] word,
    input  logic [WIDTH-1:0] colmax,
    output logic [WIDTH-1:0] max_out,
    output logic [1:0]       code
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    logic [WIDTH-1:0] mag;

    always_comb begin
        mag = word;
        if (word == MIN_NEG) begin
            mag = MAX_POS;
        end else if (word[WIDTH-1]) begin
            mag = -word;
        end
    end

    assign max_out = (mag > colmax) ? mag : colmax;

    always_comb begin
        code = PREC_FP16;
        if (max_out < THRESH_INT4) begin
            code = PREC_INT4;
        end else if (max_out < THRESH_INT8) begin
            code = PREC_INT8;
        end
    end

endmodule

// File: rtl/attention_av_loader.sv
// Stream loader filling the A/V operand buffers and firing the A*V multiplier.
// Define AV_LOADER_PRECISION_EN to compile in per-column precision selection.
module attention_av_loader
    import av_pkg::*;
#(
    parameter int                      A_ROWS      = 8,
    parameter int                      NUM_COLS    = 8,
    parameter int                      V_COLS      = 32,
    parameter int                      WIDTH_FP16  = 16,
    parameter logic [WIDTH_FP16-1:0]   THRESH_INT4 = 16'h0800,
    parameter logic [WIDTH_FP16-1:0]   THRESH_INT8 = 16'h2000
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [WIDTH_FP16-1:0]                            in_data,
    input  logic                                             in_last,
    output logic [A_ROWS-1:0][NUM_COLS-1:0][WIDTH_FP16-1:0]  a_mem,
    output logic [NUM_COLS-1:0][V_COLS-1:0][WIDTH_FP16-1:0]  v_mem,
    output logic [NUM_COLS-1:0][1:0]                         precision_sel,
    output logic                                             mult_start,
    input  logic                                             mult_done,
    output logic                                             busy,
    output logic                                             frame_err
);

    localparam int AR_W = $clog2(A_ROWS);
    localparam int AC_W = $clog2(NUM_COLS);
    localparam int VC_W = $clog2(V_COLS);

    av_state_e        state_q, state_d;
    logic [AR_W-1:0]  a_row;
    logic [AC_W-1:0]  a_col;
    logic [AC_W-1:0]  v_row;
    logic [VC_W-1:0]  v_col;

    logic xfer, in_load_a, in_load_v;
    logic a_col_end, a_last, v_row_end, v_last;
    logic abort, first_word, ok_a, ok_v;

    assign in_load_a  = (state_q == LOAD_A);
    assign in_load_v  = (state_q == LOAD_V);
    assign xfer       = in_valid && in_ready;
    assign a_col_end  = (a_row == AR_W'(A_ROWS - 1));
    assign a_last     = a_col_end && (a_col == AC_W'(NUM_COLS - 1));
    assign v_row_end  = (v_col == VC_W'(V_COLS - 1));
    assign v_last     = v_row_end && (v_row == AC_W'(NUM_COLS - 1));
    assign first_word = in_load_a && (a_row == '0) && (a_col == '0);

    // in_last must coincide exactly with the final V word of the frame
    assign abort = xfer && (in_last != (in_load_v && v_last));
    assign ok_a  = xfer && in_load_a && !abort;
    assign ok_v  = xfer && in_load_v && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        busy       = 1'b0;
        mult_start = 1'b0;
        unique case (state_q)
            LOAD_A: begin
                in_ready = 1'b1;
                if (ok_a && a_last) state_d = LOAD_V;
            end
            LOAD_V: begin
                in_ready = 1'b1;
                if (abort) begin
                    state_d = LOAD_A;
                end else if (ok_v && v_last) begin
                    state_d = FIRE;
                end
            end
            FIRE: begin
                busy       = 1'b1;
                mult_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (mult_done) state_d = LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_row <= '0;
            a_col <= '0;
            v_row <= '0;
            v_col <= '0;
        end else if (abort) begin
            a_row <= '0;
            a_col <= '0;
            v_row <= '0;
            v_col <= '0;
        end else if (ok_a) begin
            if (a_col_end) begin
                a_row <= '0;
                a_col <= a_last ? '0 : a_col + AC_W'(1);
            end else begin
                a_row <= a_row + AR_W'(1);
            end
        end else if (ok_v) begin
            if (v_row_end) begin
                v_col <= '0;
                v_row <= v_last ? '0 : v_row + AC_W'(1);
            end else begin
                v_col <= v_col + VC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mem <= '0;
            v_mem <= '0;
        end else if (ok_a) begin
            a_mem[a_row][a_col] <= in_data;
        end else if (ok_v) begin
            v_mem[v_row][v_col] <= in_data;
        end
    end

    // An erroring first word sets the flag rather than clearing it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if (abort) begin
            frame_err <= 1'b1;
        end else if (xfer && first_word) begin
            frame_err <= 1'b0;
        end
    end

`ifdef AV_LOADER_PRECISION_EN
    logic [WIDTH_FP16-1:0] colmax, col_peak;
    logic [1:0]            col_code;

    av_prec_classify #(
        .WIDTH       (WIDTH_FP16),
        .THRESH_INT4 (THRESH_INT4),
        .THRESH_INT8 (THRESH_INT8)
    ) u_classify (
        .word    (in_data),
        .colmax  (colmax),
        .max_out (col_peak),
        .code    (col_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colmax        <= '0;
            precision_sel <= {NUM_COLS{PREC_FP16}};
        end else if (abort) begin
            colmax <= '0;
        end else if (ok_a) begin
            if (a_col_end) begin
                colmax               <= '0;
                precision_sel[a_col] <= col_code;
            end else begin
                colmax <= col_peak;
            end
        end
    end
`else
    assign precision_sel = {NUM_COLS{PREC_FP16}};
`endif

endmodule

// File: tb/tb_attention_av_loader.sv
// Scoreboard bench for attention_av_loader: random frames vs a reference model.
// Honours AV_LOADER_PRECISION_EN the same way the design does.
module tb_attention_av_loader;
    import av_pkg::*;

    localparam int AR = 8;
    localparam int NC = 8;
    localparam int VC = 32;
    localparam int W  = 16;
    localparam int NA = AR * NC;
    localparam int NV = NC * VC;
    localparam int NF = NA + NV;

`ifdef AV_LOADER_PRECISION_EN
    localparam bit PREC_EN = 1'b1;
`else
    localparam bit PREC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic mult_done = 1'b0;
    logic [W-1:0] in_data = '0;
    logic in_ready, mult_start, busy, frame_err;
    logic [AR-1:0][NC-1:0][W-1:0] a_mem;
    logic [NC-1:0][VC-1:0][W-1:0] v_mem;
    logic [NC-1:0][1:0]           precision_sel;

    always #5 clk = ~clk;

    attention_av_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .a_mem         (a_mem),
        .v_mem         (v_mem),
        .precision_sel (precision_sel),
        .mult_start    (mult_start),
        .mult_done     (mult_done),
        .busy          (busy),
        .frame_err     (frame_err)
    );

    typedef struct {
        bit                           err;
        logic [AR-1:0][NC-1:0][W-1:0] a;
        logic [NC-1:0][VC-1:0][W-1:0] v;
        logic [NC-1:0][1:0]           prec;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] fw[NF];
    int           n_vec = 0;
    int           n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    function automatic int mag(logic [W-1:0] w);
        int s;
        s = 32'($signed(w));
        if (s < 0) s = -s;
        if (s > 32767) s = 32767;
        return s;
    endfunction

    function automatic logic [1:0] classify(int m);
        if (PREC_EN && m < 'h0800) return 2'b00;
        if (PREC_EN && m < 'h2000) return 2'b01;
        return 2'b10;
    endfunction

    // Expected buffers straight from the frame layout
    task automatic build_exp(bit err);
        exp_t e;
        int   peak;
        e.err = err;
        for (int c = 0; c < NC; c++) begin
            peak = 0;
            for (int r = 0; r < AR; r++) begin
                e.a[r][c] = fw[c*AR + r];
                if (mag(fw[c*AR + r]) > peak) peak = mag(fw[c*AR + r]);
            end
            e.prec[c] = classify(peak);
        end
        for (int r = 0; r < NC; r++)
            for (int c = 0; c < VC; c++)
                e.v[r][c] = fw[NA + r*VC + c];
        sb_q.push_back(e);
    endtask

    task automatic build_nominal();
        for (int c = 0; c < NC; c++) begin
            for (int r = 0; r < AR; r++) begin
                case (c)
                    0:       fw[c*AR + r] = 16'h0400;
                    1:       fw[c*AR + r] = (r == 2) ? 16'h1000 :
                                            (r == 5) ? 16'hF100 : 16'(r * 'h100);
                    2:       fw[c*AR + r] = (r == 4) ? 16'h8000 : 16'h0010;
                    default: fw[c*AR + r] = 16'h3000;
                endcase
            end
        end
        for (int r = 0; r < NC; r++)
            for (int c = 0; c < VC; c++)
                fw[NA + r*VC + c] = 16'(r * 32 + c);
    endtask

    task automatic build_random();
        int k, lim, m, pick;
        for (int c = 0; c < NC; c++) begin
            k   = $urandom_range(0, 2);
            lim = (k == 0) ? 'h0800 : (k == 1) ? 'h2000 : 'h8000;
            for (int r = 0; r < AR; r++) begin
                m = $urandom_range(0, lim - 1);
                fw[c*AR + r] = ($urandom_range(0, 1) == 1) ? 16'(-m) : 16'(m);
            end
            pick = $urandom_range(0, AR - 1);
            case ($urandom_range(0, 3))
                0:       fw[c*AR + pick] = 16'(lim - 1);
                1:       fw[c*AR + pick] = 16'(lim);
                2:       fw[c*AR + pick] = 16'(1 - lim);
                default: ;
            endcase
        end
        for (int i = NA; i < NF; i++) fw[i] = 16'($urandom);
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_a_mem"},     32'(a_mem == '0), 1);
        chk({tag, "_v_mem"},     32'(v_mem == '0), 1);
        chk({tag, "_prec"},      32'(precision_sel), 32'(16'hAAAA));
        chk({tag, "_start"},     32'(mult_start), 0);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_frame_err"}, 32'(frame_err), 0);
    endtask

    task automatic push_word(logic [W-1:0] d, logic l);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 100) begin
                n_err++;
                $display("FAIL in_ready_timeout: in_ready=0, required 1");
                summary();
                $fatal(1, "in_ready stuck");
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(int n, int last_at, bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    in_valid = 1'b0;
                    in_data  = 16'($urandom);
                    in_last  = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
                in_last = 1'b0;
            end
            push_word(fw[i], (i + 1) == last_at);
            if (i == 0 && last_at != 1)
                chk("frame_err_clear", 32'(frame_err), 0);
        end
    endtask

    // Hold a word on the bus through FIRE/WAIT, then pulse mult_done
    task automatic finish_frame();
        chk("mult_start_after_last", 32'(mult_start), 1);
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        in_last  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("in_ready_while_busy", 32'(in_ready), 0);
            chk("busy_while_busy", 32'(busy), 1);
            @(posedge clk);
            #1;
        end
        mult_done = 1'b1;
        @(posedge clk);
        #1;
        mult_done = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        chk("in_ready_after_done", 32'(in_ready), 1);
        chk("busy_after_done", 32'(busy), 0);
    endtask

    initial begin : monitor
        logic prev_err;
        logic prev_start;
        exp_t e;
        prev_err   = 1'b0;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_err   = 1'b0;
                prev_start = 1'b0;
            end else begin
                if (prev_start) chk("mult_start_width", 32'(mult_start), 0);
                if (mult_start) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_start: mult_start=1, required 0");
                    end else begin
                        e = sb_q.pop_front();
                        chk("frame_err_at_start", 32'(frame_err), 32'(e.err));
                        chk("busy_at_start", 32'(busy), 1);
                        chk("precision_sel", 32'(precision_sel), 32'(e.prec));
                        for (int r = 0; r < AR; r++)
                            for (int c = 0; c < NC; c++)
                                chk($sformatf("a_mem[%0d][%0d]", r, c),
                                    32'(a_mem[r][c]), 32'(e.a[r][c]));
                        for (int r = 0; r < NC; r++)
                            for (int c = 0; c < VC; c++)
                                chk($sformatf("v_mem[%0d][%0d]", r, c),
                                    32'(v_mem[r][c]), 32'(e.v[r][c]));
                    end
                end
                if (frame_err && !prev_err) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_frame_err: frame_err=1, required 0");
                    end else begin
                        e = sb_q.pop_front();
                        chk("frame_err_event", 32'(frame_err), 32'(e.err));
                        chk("no_start_on_err", 32'(mult_start), 0);
                    end
                end
                prev_err   = frame_err;
                prev_start = mult_start;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        rst_n = 1'b1;
        #1;
        chk("por_in_ready", 32'(in_ready), 1);

        build_nominal();
        build_exp(1'b0);
        send_frame(NF, NF, 1'b0);
        finish_frame();

        repeat (3) begin
            build_random();
            build_exp(1'b0);
            send_frame(NF, NF, 1'b1);
            finish_frame();
        end

        build_random();
        build_exp(1'b1);
        send_frame(100, 100, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_after_early_last", 32'(busy), 0);

        build_random();
        build_exp(1'b0);
        send_frame(NF, NF, 1'b1);
        finish_frame();

        build_random();
        build_exp(1'b1);
        send_frame(NF, 0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("busy_after_missing_last", 32'(busy), 0);
            chk("in_ready_after_missing_last", 32'(in_ready), 1);
        end
        @(posedge clk);
        #1;

        rst_n = 1'b0;
        #2;
        check_reset_state("rst_after_err");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_after_err_in_ready", 32'(in_ready), 1);

        build_random();
        build_exp(1'b0);
        send_frame(NF, NF, 1'b0);
        finish_frame();

        build_random();
        for (int i = 0; i < 50; i++) push_word(fw[i], 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_state("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_mid_in_ready", 32'(in_ready), 1);

        build_random();
        build_exp(1'b0);
        send_frame(NF, NF, 1'b1);
        finish_frame();

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 0);
        summary();
        $finish;
    end

endmodule
